// File: rtl/dma_write_engine_if.sv
// Signal bundle between the packet source, the DMA write engine and the DMA
// command/data/completion channels.
interface dma_write_engine_if #(
    parameter int WIDTH     = 512,
    parameter int BEAT_BITS = 16
);
    // Every channel transfers on a cycle where valid and ready are both high;
    // once valid is raised its payload holds steady until that transfer.
    logic                 req_valid;
    logic                 req_ready;
    logic [63:0]          req_address;
    logic [BEAT_BITS-1:0] req_beats;

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 in_last;

    logic                 write_cmd_valid;
    logic                 write_cmd_ready;
    logic [63:0]          write_cmd_address;
    logic [31:0]          write_cmd_length;

    logic                 write_data_valid;
    logic                 write_data_ready;
    logic [WIDTH-1:0]     write_data_data;
    logic [WIDTH/8-1:0]   write_data_keep;
    logic                 write_data_last;

    logic                 back_valid;
    logic                 back_ready;

    modport master (
        input  req_valid, req_address, req_beats,
        input  in_valid, in_data, in_last,
        input  write_cmd_ready, write_data_ready, back_valid,
        output req_ready, in_ready,
        output write_cmd_valid, write_cmd_address, write_cmd_length,
        output write_data_valid, write_data_data, write_data_keep, write_data_last,
        output back_ready
    );

    modport slave (
        output req_valid, req_address, req_beats,
        output in_valid, in_data, in_last,
        output write_cmd_ready, write_data_ready, back_valid,
        input  req_ready, in_ready,
        input  write_cmd_valid, write_cmd_address, write_cmd_length,
        input  write_data_valid, write_data_data, write_data_keep, write_data_last,
        input  back_ready
    );
endinterface

// File: rtl/dma_write_engine.sv
// Turns a packet request plus its beat stream into one DMA write command and
// the matching data burst, with a credit limit on writes awaiting completion.
module dma_write_engine #(
    parameter int WIDTH           = 512,
    parameter int MAX_OUTSTANDING = 16,
    parameter int BEAT_BITS       = 16
) (
    input  logic                                 clock,
    input  logic                                 reset,
    dma_write_engine_if.master                   bus,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic [31:0]                          done_count,
    output logic                                 len_error,
    output logic                                 idle,
    output logic [1:0]                           dbg_state
);
    localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
    localparam int SHIFT = $clog2(WIDTH / 8);
    localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [63:0]          addr_q, addr_d;
    logic [31:0]          len_q, len_d;
    logic [BEAT_BITS-1:0] rem_q, rem_d;
    logic [OW-1:0]        out_q, out_d;
    logic [31:0]          done_q, done_d;
    logic                 err_q, err_d;
    logic                 req_fire, cmd_fire, beat_fire, last_beat, back_dec;

    assign last_beat = (rem_q == BEAT_BITS'(1));

    always_comb begin
        state_d              = state_q;
        addr_d               = addr_q;
        len_d                = len_q;
        rem_d                = rem_q;
        err_d                = err_q;
        req_fire             = 1'b0;
        cmd_fire             = 1'b0;
        beat_fire            = 1'b0;
        bus.req_ready        = 1'b0;
        bus.in_ready         = 1'b0;
        bus.write_data_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                bus.req_ready = !reset && (out_q < MAX_CNT);
                req_fire      = bus.req_valid && bus.req_ready;
                // A zero-beat request is swallowed without producing a command.
                if (req_fire && (bus.req_beats != '0)) begin
                    addr_d  = bus.req_address;
                    len_d   = 32'(bus.req_beats) << SHIFT;
                    rem_d   = bus.req_beats;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                cmd_fire = bus.write_cmd_ready;
                if (cmd_fire) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                bus.write_data_valid = bus.in_valid;
                bus.in_ready         = bus.write_data_ready;
                beat_fire            = bus.in_valid && bus.write_data_ready;
                if (beat_fire) begin
                    rem_d = rem_q - BEAT_BITS'(1);
                    // The requested beat count, not in_last, ends the burst.
                    if (bus.in_last != last_beat) begin
                        err_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A completion with nothing in flight is counted but cannot underflow.
    assign back_dec = bus.back_valid && (out_q != '0);

    always_comb begin
        out_d = out_q;
        if (cmd_fire && !back_dec) begin
            out_d = out_q + OW'(1);
        end else if (!cmd_fire && back_dec) begin
            out_d = out_q - OW'(1);
        end
        done_d = done_q + (bus.back_valid ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            out_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            out_q   <= out_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.write_cmd_valid   = (state_q == S_CMD);
    assign bus.write_cmd_address = addr_q;
    assign bus.write_cmd_length  = len_q;
    assign bus.write_data_data   = bus.in_data;
    assign bus.write_data_keep   = '1;
    assign bus.write_data_last   = (state_q == S_DATA) && last_beat;
    assign bus.back_ready        = 1'b1;

    assign outstanding = out_q;
    assign done_count  = done_q;
    assign len_error   = err_q;
    assign idle        = (state_q == S_IDLE) && (out_q == '0);
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_dma_write_engine.sv
// Randomised and directed bench for dma_write_engine with a queue-based
// reference model and an independent output monitor.
module tb_dma_write_engine;
    localparam int WIDTH     = 512;
    localparam int MAX_OUT   = 2;
    localparam int BEAT_BITS = 16;
    localparam int KEEP      = WIDTH / 8;
    localparam int OW        = $clog2(MAX_OUT + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [OW-1:0] outstanding;
    logic [31:0]   done_count;
    logic          len_error;
    logic          idle;
    logic [1:0]    dbg_state;

    dma_write_engine_if #(.WIDTH(WIDTH), .BEAT_BITS(BEAT_BITS)) bus ();

    dma_write_engine #(
        .WIDTH(WIDTH), .MAX_OUTSTANDING(MAX_OUT), .BEAT_BITS(BEAT_BITS)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus.master),
        .outstanding(outstanding), .done_count(done_count),
        .len_error(len_error), .idle(idle), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: expected commands {addr,len}, beats {last,data}, counters.
    logic [95:0]    cmd_exp_q[$];
    logic [WIDTH:0] data_exp_q[$];
    logic [WIDTH-1:0] drive_q[$];
    int             exp_out = 0;
    logic [31:0]    exp_done = 0;
    logic           exp_err = 1'b0;

    int   cmd_stall = 0;
    logic cmd_ready_en = 1'b1;
    int   dready_mode = 0;
    logic [WIDTH:0] mon_e;

    task automatic chk(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // DMA-side sink: command stalls and data-ready patterns.
    initial begin
        bus.write_cmd_ready  = 1'b1;
        bus.write_data_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (cmd_stall > 0) begin
                bus.write_cmd_ready = 1'b0;
                cmd_stall--;
            end else begin
                bus.write_cmd_ready = cmd_ready_en;
            end
            case (dready_mode)
                0:       bus.write_data_ready = 1'b1;
                1:       bus.write_data_ready = ~bus.write_data_ready;
                default: bus.write_data_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: compares every presented command and transferred beat against the queues.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.write_cmd_valid) begin
                chk("cmd_expected", cmd_exp_q.size() != 0, 1);
                if (cmd_exp_q.size() != 0) begin
                    chk("cmd_addr", bus.write_cmd_address, cmd_exp_q[0][95:32]);
                    chk("cmd_len", bus.write_cmd_length, cmd_exp_q[0][31:0]);
                    if (bus.write_cmd_ready) void'(cmd_exp_q.pop_front());
                end
            end
            if (bus.write_data_valid) begin
                chk("in_ready_mirror", bus.in_ready, bus.write_data_ready);
                if (bus.write_data_ready) begin
                    chk("beat_expected", data_exp_q.size() != 0, 1);
                    if (data_exp_q.size() != 0) begin
                        mon_e = data_exp_q.pop_front();
                        chk("beat_data", bus.write_data_data, mon_e[WIDTH-1:0]);
                        chk("beat_last", bus.write_data_last, mon_e[WIDTH]);
                        chk("beat_keep", bus.write_data_keep, {KEEP{1'b1}});
                    end
                end
            end
        end
    end

    function automatic logic [WIDTH-1:0] rand_word();
        logic [WIDTH-1:0] w;
        for (int k = 0; k < WIDTH / 32; k++) w[k*32 +: 32] = $urandom();
        return w;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_mode(input int stall, input logic ready_en, input int dmode);
        @(negedge clock);
        cmd_stall    = stall;
        cmd_ready_en = ready_en;
        dready_mode  = dmode;
        tick(1);
    endtask

    task automatic check_reset_vals();
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_cmd_valid", bus.write_cmd_valid, 0);
        chk("rst_cmd_addr", bus.write_cmd_address, 0);
        chk("rst_cmd_len", bus.write_cmd_length, 0);
        chk("rst_data_valid", bus.write_data_valid, 0);
        chk("rst_data_last", bus.write_data_last, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_done_count", done_count, 0);
        chk("rst_len_error", len_error, 0);
        chk("rst_back_ready", bus.back_ready, 1);
        chk("rst_idle", idle, 1);
    endtask

    task automatic reset_dut();
        @(posedge clock);
        #1;
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        bus.back_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_reset_vals();
        cmd_exp_q.delete();
        data_exp_q.delete();
        drive_q.delete();
        exp_out = 0;
        exp_done = 0;
        exp_err = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic push_packet(input logic [63:0] addr, input int beats, input int base);
        logic [WIDTH-1:0] d;
        if (beats != 0) begin
            cmd_exp_q.push_back({addr, 32'(beats) * 32'(KEEP)});
            for (int i = 0; i < beats; i++) begin
                d = (base != 0) ? WIDTH'(base + i) : rand_word();
                data_exp_q.push_back({(i == beats - 1), d});
                drive_q.push_back(d);
            end
            exp_out++;
        end
        bus.req_address = addr;
        bus.req_beats = BEAT_BITS'(beats);
        bus.req_valid = 1'b1;
    endtask

    task automatic wait_req();
        bit ok = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clock);
            if (bus.req_ready) begin
                ok = 1;
                break;
            end
        end
        chk("req_accept", ok, 1);
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic start_packet(input logic [63:0] addr, input int beats, input int base);
        push_packet(addr, beats, base);
        wait_req();
    endtask

    task automatic send_beats(input int n, input int last_at, input bit gaps);
        bit ok;
        for (int i = 0; i < n; i++) begin
            if (drive_q.size() == 0) break;
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                tick(1);
            end
            bus.in_data = drive_q.pop_front();
            bus.in_last = (i == last_at);
            bus.in_valid = 1'b1;
            ok = 0;
            for (int c = 0; c < 200; c++) begin
                @(negedge clock);
                if (bus.in_ready) begin
                    ok = 1;
                    break;
                end
            end
            chk("beat_accept", ok, 1);
            tick(1);
        end
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
    endtask

    task automatic back_pulse();
        bus.back_valid = 1'b1;
        tick(1);
        bus.back_valid = 1'b0;
        if (exp_out > 0) exp_out--;
        exp_done++;
    endtask

    task automatic check_status(input string tag);
        @(negedge clock);
        chk({tag, "_outstanding"}, outstanding, exp_out);
        chk({tag, "_done_count"}, done_count, exp_done);
        chk({tag, "_len_error"}, len_error, exp_err);
        chk({tag, "_idle"}, idle, exp_out == 0);
        tick(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        int b;
        bus.req_valid = 1'b0;
        bus.req_address = '0;
        bus.req_beats = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_last = 1'b0;
        bus.back_valid = 1'b0;
        reset_dut();

        // Single 4-beat packet, completion ten cycles later.
        start_packet(64'h1000, 4, 1);
        send_beats(4, 3, 0);
        tick(10);
        check_status("single_pre");
        back_pulse();
        check_status("single");

        // Command stall then alternating data ready.
        set_mode(7, 1'b1, 1);
        start_packet(64'h2000, 4, 'hA);
        send_beats(4, 3, 0);
        set_mode(0, 1'b1, 0);
        back_pulse();
        check_status("bp");

        // Credit limit: third request waits for a completion.
        start_packet(64'h3000, 1, 0);
        send_beats(1, 0, 0);
        start_packet(64'h3040, 1, 0);
        send_beats(1, 0, 0);
        check_status("credit_full");
        push_packet(64'h3080, 1, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("credit_stall", bus.req_ready, 0);
        end
        tick(1);
        back_pulse();
        @(negedge clock);
        chk("credit_release", bus.req_ready, 1);
        tick(1);
        bus.req_valid = 1'b0;
        send_beats(1, 0, 0);
        check_status("credit_third");
        back_pulse();
        back_pulse();
        check_status("credit_drain");

        // Zero-beat request and a spurious completion.
        start_packet(64'h4000, 0, 0);
        tick(5);
        check_status("zero_beats");
        back_pulse();
        check_status("spurious_back");

        // Command fire and completion in the same cycle.
        start_packet(64'h5000, 1, 0);
        send_beats(1, 0, 0);
        set_mode(0, 1'b0, 0);
        start_packet(64'h5040, 1, 0);
        @(negedge clock);
        cmd_ready_en = 1'b1;
        @(posedge clock);
        #1;
        bus.back_valid = 1'b1;
        tick(1);
        bus.back_valid = 1'b0;
        exp_out--;
        exp_done++;
        @(negedge clock);
        chk("simul_outstanding", outstanding, exp_out);
        tick(1);
        send_beats(1, 0, 0);
        back_pulse();
        check_status("simul");

        // Randomised packets, ready patterns and completions.
        for (int p = 0; p < 25; p++) begin
            if (exp_out >= MAX_OUT) back_pulse();
            a = {$urandom(), $urandom()};
            a[5:0] = '0;
            b = $urandom_range(0, 6);
            set_mode($urandom_range(0, 3), 1'b1, $urandom_range(0, 2));
            start_packet(a, b, 0);
            send_beats(b, b - 1, 1);
            if (exp_out > 0 && $urandom_range(0, 1) == 1) back_pulse();
        end
        set_mode(0, 1'b1, 0);
        while (exp_out > 0) back_pulse();
        check_status("random");

        // in_last early: beat count still governs, error is sticky.
        start_packet(64'h6000, 3, 'h100);
        send_beats(3, 1, 0);
        exp_err = 1'b1;
        back_pulse();
        check_status("len_mismatch");
        start_packet(64'h6100, 1, 0);
        send_beats(1, 0, 0);
        back_pulse();
        check_status("len_sticky");

        // Reset in the middle of an 8-beat burst, then a clean packet.
        start_packet(64'h7000, 8, 0);
        send_beats(2, 7, 0);
        reset_dut();
        start_packet(64'h8000, 1, 0);
        send_beats(1, 0, 0);
        back_pulse();
        check_status("post_reset");

        chk("queues_drained", cmd_exp_q.size() + data_exp_q.size() + drive_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
